risc_v_32_mem_arb: RTL

RISC_V_32_MEM_ARB -- requirements
Module: risc_v_32_mem_arb

---
 rtl/risc_v_32_pkg.sv | 18 +
 rtl/risc_v_32_arb_pick.sv | 30 +++
 rtl/risc_v_32_mem_arb.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/risc_v_32_pkg.sv
// Shared definitions for the RV32 instruction/data memory arbiter.
//   state_e   : arbiter FSM state encoding (2 bits)
//   REQ_I/D   : requester identifiers (fetch port / data port)
//   CNT_W     : width of the fetch-starvation counter (holds 0..7)
package risc_v_32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int CNT_W = 3;

endpackage

// File: rtl/risc_v_32_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Data normally wins; fetch wins when it is requesting and has already
// waited through STARVE_MAX consecutive data grants.
//   i_req, d_req : request lines from fetch / data ports
//   starve_cnt   : consecutive data grants made while fetch was waiting
//   grant        : some requester is asking
//   pick         : REQ_I or REQ_D, valid when grant is 1
module risc_v_32_arb_pick
    import risc_v_32_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant,
    output logic             pick
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic fetch_due;

    always_comb begin
        fetch_due = i_req && (starve_cnt == STARVE_LIM);
        grant     = i_req | d_req;
        pick      = (d_req && !fetch_due) ? REQ_D : REQ_I;
    end

endmodule

// File: rtl/risc_v_32_mem_arb.sv
// Arbiter sharing one single-outstanding memory port between the IF-stage
// fetch port and the MEM-stage data port.
//   clk, clr                      : clock, asynchronous active-high reset
//   i_req/i_addr -> i_done/i_rdata: instruction fetch request / completion
//   d_req/d_we/d_addr/d_wdata/d_be -> d_done/d_rdata: load/store request
//   mem_req/we/addr/wdata/be      : registered command to memory
//   mem_ready/mem_rdata           : memory completion, read data same cycle
// Every transaction walks IDLE -> BUSY -> RESP, so at most one is in flight.
module risc_v_32_mem_arb
    import risc_v_32_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             owner_q, owner_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic             i_done_q, i_done_d;
    logic             d_done_q, d_done_d;
    logic [31:0]      i_rdata_q, i_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;

    logic grant;
    logic pick;

    risc_v_32_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_q),
        .grant      (grant),
        .pick       (pick)
    );

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d   = ST_BUSY;
                    mem_req_d = 1'b1;
                    owner_d   = pick;
                    if (pick == REQ_D) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_be;
                        // Only data grants that make a live fetch wait count
                        // towards starvation.
                        if (i_req && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = 32'h0;
                        mem_be_d    = 4'hF;
                        starve_d    = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    // Done and read data are registered together so the
                    // pulse in RESP already carries the matching word.
                    if (owner_q == REQ_D) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_done_d  = 1'b1;
                        i_rdata_d = mem_rdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            owner_q     <= REQ_I;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
